// File: rtl/spi_cmd_pkg.sv
// Shared types and defaults for the SPI command controller.
package spi_cmd_pkg;

    localparam int unsigned AddrWDefault = 7;
    localparam int unsigned DataWDefault = 8;
    localparam int unsigned RwBit        = 7;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWdata,
        StRdata
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, synchronous reset to ResetVal.
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder driving an external register bank: command byte, then write or read burst.
// Define SPI_CMD_AUTOINC_EN to step the register address after every data byte.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csn,
    input  logic [DATA_W-1:0] recv,
    input  logic              output_valid,
    output logic [DATA_W-1:0] send,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_done
);

    logic csn_s;

    sync_2ff #(
        .ResetVal(1'b1)
    ) u_csn_sync (
        .clk(clk),
        .rst(rst),
        .d  (csn),
        .q  (csn_s)
    );

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] send_q, send_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              frame_done_q, frame_done_d;
    logic              load_q, load_d;

`ifdef SPI_CMD_AUTOINC_EN
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        send_d       = send_q;
        reg_wdata_d  = reg_wdata_q;
        reg_we_d     = 1'b0;
        frame_done_d = 1'b0;
        load_d       = 1'b0;

        // reg_rdata reflects addr_q, so the reload lands one cycle after the strobe.
        if (load_q) begin
            send_d = reg_rdata;
        end

`ifdef SPI_CMD_AUTOINC_EN
        // Step only after the write strobe has used the current address.
        if (reg_we_q) begin
            addr_d = addr_q + AddrOne;
        end
`endif

        unique case (state_q)
            StIdle: begin
                if (!csn_s) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (output_valid) begin
                    addr_d  = recv[ADDR_W-1:0];
                    rw_d    = recv[RwBit];
                    load_d  = recv[RwBit];
                    state_d = recv[RwBit] ? StRdata : StWdata;
                end
            end
            StWdata: begin
                if (output_valid) begin
                    reg_we_d    = 1'b1;
                    reg_wdata_d = recv;
                end
            end
            StRdata: begin
                if (output_valid) begin
                    load_d = 1'b1;
`ifdef SPI_CMD_AUTOINC_EN
                    addr_d = addr_q + AddrOne;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // End of frame overrides the state move but keeps any byte work above.
        if (csn_s && (state_q != StIdle)) begin
            state_d      = StIdle;
            frame_done_d = (state_q != StCmd) || output_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            send_q       <= '0;
            reg_wdata_q  <= '0;
            reg_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            send_q       <= send_d;
            reg_wdata_q  <= reg_wdata_d;
            reg_we_q     <= reg_we_d;
            frame_done_q <= frame_done_d;
            load_q       <= load_d;
        end
    end

    assign send       = send_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_we     = reg_we_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed, table-driven bench for spi_cmd_ctrl with a behavioural register bank.
module tb_spi_cmd_ctrl;

`ifdef SPI_CMD_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       csn;
    logic [7:0] recv;
    logic       output_valid;
    logic [7:0] send;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       frame_done;

    spi_cmd_ctrl #(
        .ADDR_W(7),
        .DATA_W(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csn         (csn),
        .recv        (recv),
        .output_valid(output_valid),
        .send        (send),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_rdata   (reg_rdata),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] bank [128];
    logic [6:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         fd_cnt = 0;

    assign reg_rdata = bank[reg_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) bank[i] <= 8'h00;
            bank[3] <= 8'h11;
            bank[4] <= 8'h22;
        end else if (reg_we) begin
            bank[reg_addr] <= reg_wdata;
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        csn = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        csn = 1'b1;
        tick(6);
    endtask

    // One-cycle strobe; returns 1 time unit after the edge that sampled it.
    task automatic strobe(input logic [7:0] b);
        recv         = b;
        output_valid = 1'b1;
        tick(1);
        output_valid = 1'b0;
        recv         = 8'h00;
    endtask

    typedef struct {
        string           name;
        int              n;
        logic [2:0][7:0] b;
        bit              sim_end;
        int              nw;
        logic [6:0]      a0;
        logic [6:0]      a1_inc;
        logic [6:0]      a1_fix;
        logic [7:0]      d0;
        logic [7:0]      d1;
        int              fd;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         ws;
        int         fd0;
        logic [6:0] ea;
        logic [7:0] ed;
        logic [6:0] ga;
        logic [7:0] gd;

        vecs[0] = '{"wr_burst",  3, {8'hBB, 8'hAA, 8'h05}, 1'b0, 2, 7'h05, 7'h06, 7'h05, 8'hAA, 8'hBB, 1};
        vecs[1] = '{"wrap",      3, {8'h02, 8'h01, 8'h7F}, 1'b0, 2, 7'h7F, 7'h00, 7'h7F, 8'h01, 8'h02, 1};
        vecs[2] = '{"cmd_only",  1, {8'h00, 8'h00, 8'h05}, 1'b0, 0, 7'h00, 7'h00, 7'h00, 8'h00, 8'h00, 1};
        vecs[3] = '{"sim_end",   3, {8'hDD, 8'hCC, 8'h10}, 1'b1, 2, 7'h10, 7'h11, 7'h10, 8'hCC, 8'hDD, 1};
        vecs[4] = '{"single_wr", 2, {8'h00, 8'h5A, 8'h2A}, 1'b0, 1, 7'h2A, 7'h00, 7'h00, 8'h5A, 8'h00, 1};

        rst = 1'b1; csn = 1'b1; recv = 8'h00; output_valid = 1'b0;
        tick(3);
        check("rst_send", send, 8'h00);
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_reg_addr", reg_addr, 7'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        tick(3);

        // Read burst with one-cycle reload latency.
        ws = wr_addr_q.size(); fd0 = fd_cnt;
        frame_start();
        strobe(8'h83);
        check("rd_send_latency", send, 8'h00);
        tick(1);
        check("rd_send_first", send, 8'h11);
        tick(3);
        strobe(8'h00);
        check("rd_send_hold", send, 8'h11);
        tick(1);
        check("rd_send_second", send, AutoInc ? 8'h22 : 8'h11);
        tick(4);
        check("rd_send_stable", send, AutoInc ? 8'h22 : 8'h11);
        frame_end();
        check("rd_no_writes", wr_addr_q.size() - ws, 0);
        check("rd_frame_done", fd_cnt - fd0, 1);

        for (int v = 0; v < 5; v++) begin
            ws = wr_addr_q.size(); fd0 = fd_cnt;
            frame_start();
            for (int k = 0; k < vecs[v].n; k++) begin
                if (vecs[v].sim_end && (k == vecs[v].n - 1)) begin
                    csn = 1'b1;
                    @(posedge clk);
                    @(posedge clk);
                    #1;
                    strobe(vecs[v].b[k]);
                    check({vecs[v].name, "_we"}, reg_we, 1'b1);
                    check({vecs[v].name, "_fd"}, frame_done, 1'b1);
                    check({vecs[v].name, "_addr"}, reg_addr,
                          AutoInc ? vecs[v].a1_inc : vecs[v].a1_fix);
                    check({vecs[v].name, "_wdata"}, reg_wdata, vecs[v].d1);
                    tick(1);
                    check({vecs[v].name, "_fd_once"}, frame_done, 1'b0);
                end else begin
                    strobe(vecs[v].b[k]);
                    tick(3);
                end
            end
            frame_end();
            check({vecs[v].name, "_nwrites"}, wr_addr_q.size() - ws, vecs[v].nw);
            check({vecs[v].name, "_nframes"}, fd_cnt - fd0, vecs[v].fd);
            for (int k = 0; k < vecs[v].nw; k++) begin
                ea = (k == 0) ? vecs[v].a0 : (AutoInc ? vecs[v].a1_inc : vecs[v].a1_fix);
                ed = (k == 0) ? vecs[v].d0 : vecs[v].d1;
                ga = (ws + k < wr_addr_q.size()) ? wr_addr_q[ws + k] : 'x;
                gd = (ws + k < wr_data_q.size()) ? wr_data_q[ws + k] : 'x;
                check({vecs[v].name, "_waddr"}, ga, ea);
                check({vecs[v].name, "_wdata_log"}, gd, ed);
            end
        end

        // Reset in the middle of a write burst.
        frame_start();
        strobe(8'h20);
        tick(3);
        strobe(8'h55);
        tick(3);
        ws = wr_addr_q.size(); fd0 = fd_cnt;
        rst = 1'b1;
        csn = 1'b1;
        tick(1);
        check("mid_rst_send", send, 8'h00);
        check("mid_rst_reg_we", reg_we, 1'b0);
        check("mid_rst_reg_addr", reg_addr, 7'h00);
        check("mid_rst_reg_wdata", reg_wdata, 8'h00);
        check("mid_rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        tick(6);
        strobe(8'h66);
        tick(4);
        check("mid_rst_no_write", wr_addr_q.size() - ws, 0);
        check("mid_rst_no_frame", fd_cnt - fd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
